// File: rtl/fetch_seq.sv
// fetch_seq: 6502 instruction-cycle sequencer producing SYNC, T-state and interrupt-injected BRK decisions
module fetch_seq #(
  parameter int MAX_T = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rdy,
  input  logic       last_cycle,
  input  logic       nmi_n,
  input  logic       irq_n,
  input  logic       i_flag,
  output logic       sync,
  output logic [2:0] t_state,
  output logic       force_brk,
  output logic       pc_inc,
  output logic [1:0] int_kind,
  output logic       t_stuck
);
  typedef enum logic {FETCH, EXEC} state_t;
  localparam logic [2:0] T_MAX = 3'(MAX_T);
  state_t state, state_nx;
  logic [2:0] t_nx;
  logic brk_nx, inc_nx, stuck_nx, lat_nx, nmi_lat, nmi_prev, irq_take;
  logic [1:0] kind_nx;
  assign sync = (state == FETCH);
  assign irq_take = !irq_n && !i_flag;
  // next-state, T-state advance and boundary interrupt decision; everything holds when rdy=0
  always_comb begin
    state_nx = state;
    t_nx = t_state;
    brk_nx = force_brk;
    inc_nx = pc_inc;
    kind_nx = int_kind;
    stuck_nx = t_stuck;
    lat_nx = (nmi_prev && !nmi_n) ||
             (nmi_lat && !(rdy && state == FETCH && int_kind == 2'b10));
    if (rdy) begin
      if (state == FETCH) begin
        state_nx = EXEC;
        t_nx = 3'd1;
      end else if (last_cycle) begin
        state_nx = FETCH;
        t_nx = 3'd0;
        kind_nx = nmi_lat ? 2'b10 : irq_take ? 2'b01 : 2'b00;
        brk_nx = nmi_lat || irq_take;
        inc_nx = !(nmi_lat || irq_take);
      end else begin
        t_nx = (t_state == T_MAX) ? t_state : t_state + 3'd1;
        stuck_nx = t_stuck || (t_state == T_MAX);
      end
    end
  end
  // state registers; the NMI edge detector samples every cycle regardless of rdy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FETCH;
      t_state <= 3'd0;
      force_brk <= 1'b1;
      pc_inc <= 1'b0;
      int_kind <= 2'b11;
      t_stuck <= 1'b0;
      nmi_lat <= 1'b0;
      nmi_prev <= 1'b1;
    end else begin
      state <= state_nx;
      t_state <= t_nx;
      force_brk <= brk_nx;
      pc_inc <= inc_nx;
      int_kind <= kind_nx;
      t_stuck <= stuck_nx;
      nmi_lat <= lat_nx;
      nmi_prev <= nmi_n;
    end
  end
endmodule

// File: tb/tb_fetch_seq.sv
// tb_fetch_seq: directed and randomized checks of fetch_seq against a cycle-level behavioural model
module tb_fetch_seq;
  logic clk = 1'b0, rst_n = 1'b0, rdy = 1'b1, last_cycle = 1'b0;
  logic nmi_n = 1'b1, irq_n = 1'b1, i_flag = 1'b1;
  logic sync, force_brk, pc_inc, t_stuck;
  logic [2:0] t_state;
  logic [1:0] int_kind;
  int n_checks = 0, n_fail = 0;
  bit m_sync, m_brk, m_inc, m_stuck, m_nmi_pending, m_nmi_last;
  int m_t;
  logic [1:0] m_kind;

  fetch_seq dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .last_cycle(last_cycle), .nmi_n(nmi_n),
    .irq_n(irq_n), .i_flag(i_flag), .sync(sync), .t_state(t_state), .force_brk(force_brk),
    .pc_inc(pc_inc), .int_kind(int_kind), .t_stuck(t_stuck)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] obs();
    return {sync, t_state, force_brk, pc_inc, int_kind, t_stuck};
  endfunction

  function automatic logic [8:0] expv();
    return {m_sync, 3'(m_t), m_brk, m_inc, m_kind, m_stuck};
  endfunction

  task automatic model_reset();
    m_sync = 1; m_t = 0; m_brk = 1; m_inc = 0; m_kind = 2'b11; m_stuck = 0;
    m_nmi_pending = 0; m_nmi_last = 1;
  endtask

  // one clock of the instruction-cycle rules, applied to the inputs present at the edge
  task automatic model_edge();
    bit fell, consumed;
    fell = m_nmi_last && !nmi_n;
    consumed = rdy && m_sync && m_kind == 2'b10;
    m_nmi_last = nmi_n;
    if (rdy) begin
      if (m_sync) begin
        m_sync = 0; m_t = 1;
      end else if (last_cycle) begin
        m_sync = 1; m_t = 0;
        if (m_nmi_pending) begin m_kind = 2'b10; m_brk = 1; m_inc = 0; end
        else if (!irq_n && !i_flag) begin m_kind = 2'b01; m_brk = 1; m_inc = 0; end
        else begin m_kind = 2'b00; m_brk = 0; m_inc = 1; end
      end else begin
        if (m_t == 7) m_stuck = 1;
        m_t = (m_t + 1 > 7) ? 7 : m_t + 1;
      end
    end
    m_nmi_pending = fell || (m_nmi_pending && !consumed);
  endtask

  task automatic step(input logic r, input logic l);
    rdy = r; last_cycle = l;
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task test_reset();
    nmi_n = 1; irq_n = 1; i_flag = 1;
    do_reset();
    n_checks++;
    if ({sync, t_state, force_brk, pc_inc, int_kind, t_stuck} !== 9'b1_000_1_0_11_0) begin
      n_fail++; $display("FAIL reset_values got %b want %b", obs(), 9'b1_000_1_0_11_0);
    end
    step(1, 0);
    n_checks++;
    if (sync !== 1'b0 || t_state !== 3'd1) begin
      n_fail++; $display("FAIL reset_t1 got sync=%b t=%0d want sync=0 t=1", sync, t_state);
    end
    step(1, 1);
    n_checks++;
    if (sync !== 1'b1 || int_kind !== 2'b00 || pc_inc !== 1'b1 || obs() !== expv()) begin
      n_fail++; $display("FAIL reset_second_sync got %b want %b", obs(), expv());
    end
  endtask

  task test_normal();
    logic [7:0] pat;
    pat = '0;
    for (int i = 0; i < 8; i++) begin
      pat = {pat[6:0], sync};
      step(1, (i % 4) == 3);
    end
    n_checks++;
    if (pat !== 8'b1000_1000) begin
      n_fail++; $display("FAIL normal_sync_pattern got %b want 10001000", pat);
    end
    n_checks++;
    if (pc_inc !== 1'b1 || force_brk !== 1'b0 || obs() !== expv()) begin
      n_fail++; $display("FAIL normal_fetch got %b want %b", obs(), expv());
    end
  endtask

  task test_rdy_stall();
    int len;
    step(1, 0);
    step(1, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 1);
      n_checks++;
      if (t_state !== 3'd2 || sync !== 1'b0 || obs() !== expv()) begin
        n_fail++; $display("FAIL rdy_hold_%0d got %b want %b (t=2)", i, obs(), expv());
      end
    end
    len = 5;
    step(1, 0);
    step(1, 1);
    len += 2;
    n_checks++;
    if (sync !== 1'b1 || len !== 7 || obs() !== expv()) begin
      n_fail++; $display("FAIL rdy_stretch got %b want %b", obs(), expv());
    end
  endtask

  task test_nmi_irq();
    irq_n = 0; i_flag = 0;
    step(1, 0);
    nmi_n = 0;
    step(1, 0);
    nmi_n = 1;
    step(1, 1);
    n_checks++;
    if (int_kind !== 2'b10 || force_brk !== 1'b1 || pc_inc !== 1'b0 || obs() !== expv()) begin
      n_fail++; $display("FAIL nmi_fetch got %b want kind=10 (%b)", obs(), expv());
    end
    step(1, 0);
    step(1, 1);
    n_checks++;
    if (int_kind !== 2'b01 || force_brk !== 1'b1 || obs() !== expv()) begin
      n_fail++; $display("FAIL irq_after_nmi got %b want kind=01 (%b)", obs(), expv());
    end
    irq_n = 1;
  endtask

  task test_irq_mask();
    irq_n = 0; i_flag = 1;
    step(1, 0);
    step(1, 1);
    n_checks++;
    if (int_kind !== 2'b00 || pc_inc !== 1'b1 || force_brk !== 1'b0) begin
      n_fail++; $display("FAIL irq_masked got %b want kind=00 pc_inc=1", obs());
    end
    i_flag = 0;
    step(1, 0);
    step(1, 1);
    n_checks++;
    if (int_kind !== 2'b01 || pc_inc !== 1'b0 || force_brk !== 1'b1) begin
      n_fail++; $display("FAIL irq_taken got %b want kind=01 pc_inc=0", obs());
    end
    irq_n = 1; i_flag = 1;
  endtask

  task test_stuck_and_async_reset();
    for (int i = 0; i < 10; i++) step(1, 0);
    n_checks++;
    if (t_state !== 3'd7 || t_stuck !== 1'b1 || obs() !== expv()) begin
      n_fail++; $display("FAIL stuck_saturate got %b want t=7 stuck=1 (%b)", obs(), expv());
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (obs() !== 9'b1_000_1_0_11_0) begin
      n_fail++; $display("FAIL async_reset got %b want 100010110", obs());
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task test_random();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(7) == 0) nmi_n = ~nmi_n;
      if ($urandom_range(3) == 0) irq_n = ~irq_n;
      if ($urandom_range(5) == 0) i_flag = ~i_flag;
      step($urandom_range(4) != 0, $urandom_range(2) == 0);
      n_checks++;
      if (obs() !== expv()) begin
        n_fail++; $display("FAIL random_cycle_%0d got %b want %b", i, obs(), expv());
      end
    end
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    test_reset();
    test_normal();
    test_rdy_stall();
    test_nmi_irq();
    test_irq_mask();
    test_stuck_and_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
